// File: rtl/aes_pkg.sv
// Shared AES byte-serial datapath definitions: state size, byte type and
// the ShiftRows index mapping used by the byte-serial permutation stages.
package aes_pkg;

  localparam int STATE_BYTES = 16;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] idx_t;

  // Column-major state index k holds row k[1:0], column k[3:2].
  // Forward ShiftRows rotates row r left by r, so output (r, c) takes
  // input (r, (c + r) mod 4); the 2-bit add supplies the mod 4.
  function automatic idx_t sr_index(input idx_t k);
    logic [1:0] row;
    logic [1:0] col;
    row = k[1:0];
    col = k[3:2] + row;
    return {col, row};
  endfunction

endpackage

// File: rtl/shift_rows_bank.sv
// One 16 x 8 state buffer: synchronous write port, combinational read port.
// Contents are not reset; the owner's full flags decide when data is valid.
module shift_rows_bank
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  byte_t mem_q [STATE_BYTES];
  byte_t mem_d [STATE_BYTES];

  // Next contents: the addressed entry takes the write data when enabled.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage update; data only, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Asynchronous read of the addressed entry.
  always_comb begin
    rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Byte-serial forward ShiftRows: fills one ping-pong bank in arrival order
// while draining the other through the SR permutation, one byte per cycle
// on each side with valid/ready back-pressure.
module shift_rows_stream
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last
);

  localparam idx_t LAST_IDX = idx_t'(STATE_BYTES - 1);

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  idx_t       wr_cnt_q, wr_cnt_d;
  idx_t       rd_cnt_q, rd_cnt_d;

  logic       in_fire, out_fire;
  logic       wr_done, rd_done;
  logic [1:0] bank_we;
  idx_t       rd_idx;
  byte_t      rd_data [2];

  // Handshake and output decode; everything here depends only on registers
  // except the fire terms, so there is no in_* to out_* combinational path.
  always_comb begin
    in_ready   = !full_q[wr_bank_q];
    out_valid  = full_q[rd_bank_q];
    out_last   = out_valid && (rd_cnt_q == LAST_IDX);
    out_byte   = rd_data[rd_bank_q];
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    wr_done    = in_fire && (wr_cnt_q == LAST_IDX);
    rd_done    = out_fire && (rd_cnt_q == LAST_IDX);
    rd_idx     = sr_index(rd_cnt_q);
    bank_we    = '0;
    bank_we[wr_bank_q] = in_fire;
  end

  // Pointer and flag update. Write only targets a non-full bank and read
  // only a full one, so a simultaneous completion always touches two
  // different banks and both flag updates can apply in the same cycle.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + idx_t'(1);
    end
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + idx_t'(1);
    end
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  // Control registers; reset drops every partial or undrained block.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    shift_rows_bank u_bank (
      .clk     (clk),
      .wr_en   (bank_we[b]),
      .wr_addr (wr_cnt_q),
      .wr_data (in_byte),
      .rd_addr (rd_idx),
      .rd_data (rd_data[b])
    );
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: table vectors, back-to-back, back-pressure,
// random handshakes and mid-block reset, all scored through a queue.
module tb_shift_rows_stream;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0] din  [16];
    logic [7:0] dout [16];
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] in_q [$];
  exp_t       exp_q [$];
  logic [7:0] blk_buf [16];
  int         blk_n;
  int         in_prob, out_prob;
  bit         use_model;
  bit         strict;
  int         strict_out_total;
  int         in_gap, out_gap, first_out_iter, out_count, accepted, hold_err;

  shift_rows_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Reference mapping written straight from the row/column definition.
  function automatic int sr(input int k);
    return 4 * (((k / 4) + (k % 4)) % 4) + (k % 4);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_byte   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    in_q.delete();
    exp_q.delete();
    blk_n = 0; accepted = 0; out_count = 0; first_out_iter = -1;
    in_gap = 0; out_gap = 0; hold_err = 0; strict = 1'b0; use_model = 1'b1;
  endtask

  // Cycle engine: drive after the edge, sample at the falling edge.
  task automatic run(input int ncyc, input bit until_done);
    bit         prev_hold;
    logic [7:0] prev_b, b;
    logic       prev_l;
    exp_t       e;
    prev_hold = 1'b0;
    prev_b = 8'h00;
    prev_l = 1'b0;
    for (int it = 0; ; it++) begin
      if (until_done && in_q.size() == 0 && exp_q.size() == 0 && blk_n == 0) break;
      if (it >= ncyc) begin
        if (until_done) begin
          vectors++;
          miscompares++;
          $display("FAIL timeout: %0d bytes still pending after %0d cycles, expected 0",
                   in_q.size() + exp_q.size(), ncyc);
        end
        break;
      end
      in_valid  = (in_q.size() > 0) && ($urandom_range(99) < in_prob);
      in_byte   = in_valid ? in_q[0] : 8'($urandom);
      out_ready = ($urandom_range(99) < out_prob);
      @(negedge clk);
      if (prev_hold && out_valid && (out_byte !== prev_b || out_last !== prev_l)) hold_err++;
      prev_hold = out_valid && !out_ready;
      prev_b    = out_byte;
      prev_l    = out_last;
      if (strict && in_q.size() > 0 && !in_ready) in_gap++;
      if (strict && first_out_iter >= 0 && out_count < strict_out_total && !out_valid) out_gap++;
      if (out_valid && first_out_iter < 0) first_out_iter = it;
      if (in_valid && in_ready) begin
        accepted++;
        b = in_q.pop_front();
        if (use_model) begin
          blk_buf[blk_n] = b;
          blk_n++;
          if (blk_n == 16) begin
            for (int k = 0; k < 16; k++) exp_q.push_back('{blk_buf[sr(k)], k == 15});
            blk_n = 0;
          end
        end
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got %h, expected no output", out_byte);
        end else begin
          e = exp_q.pop_front();
          chk("out_byte", out_byte, e.b);
          chk("out_last", 8'(out_last), 8'(e.last));
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic push_random_blocks(input int n);
    for (int i = 0; i < n * 16; i++) in_q.push_back(8'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs [2];
    vecs[0].din  = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                     8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    vecs[0].dout = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                     8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    vecs[1].din  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                     8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f};
    vecs[1].dout = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                     8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};

    // Reset state
    do_reset();
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_out_last", 8'(out_last), 8'd0);

    // Table vectors: expected bytes come from the table, not the model
    for (int v = 0; v < 2; v++) begin
      do_reset();
      use_model = 1'b0;
      for (int k = 0; k < 16; k++) begin
        in_q.push_back(vecs[v].din[k]);
        exp_q.push_back('{vecs[v].dout[k], k == 15});
      end
      in_prob = 100; out_prob = 100;
      run(200, 1'b1);
      chk("vec_latency", 8'(first_out_iter), 8'd16);
    end

    // Back-to-back: 4 blocks, including the coincident 16th write / 16th read
    do_reset();
    push_random_blocks(4);
    strict = 1'b1; strict_out_total = 64;
    in_prob = 100; out_prob = 100;
    run(400, 1'b1);
    chk("b2b_first_out", 8'(first_out_iter), 8'd16);
    chk("b2b_in_gaps", 8'(in_gap), 8'd0);
    chk("b2b_out_gaps", 8'(out_gap), 8'd0);
    chk("b2b_out_count", 8'(out_count), 8'd64);

    // Back-pressure: stall output 40 cycles, then drain in order
    do_reset();
    push_random_blocks(3);
    in_prob = 100; out_prob = 0;
    run(40, 1'b0);
    chk("bp_accepted", 8'(accepted), 8'd32);
    chk("bp_in_ready", 8'(in_ready), 8'd0);
    chk("bp_out_valid", 8'(out_valid), 8'd1);
    chk("bp_hold_stable", 8'(hold_err), 8'd0);
    out_prob = 100;
    run(400, 1'b1);
    chk("bp_drain_count", 8'(out_count), 8'd48);

    // Random toggling on both sides over 100 blocks
    do_reset();
    push_random_blocks(100);
    in_prob = 60; out_prob = 55;
    run(30000, 1'b1);
    chk("rand_hold_stable", 8'(hold_err), 8'd0);
    vectors++;
    if (out_count != 1600) begin
      miscompares++;
      $display("FAIL rand_out_count: got %0d, expected 1600", out_count);
    end

    // Mid-block reset: block 1 partly drained, 7 bytes of block 2 written
    do_reset();
    push_random_blocks(2);
    in_prob = 100; out_prob = 100;
    run(23, 1'b0);
    chk("pre_rst_accepted", 8'(accepted), 8'd23);
    chk("pre_rst_out_valid", 8'(out_valid), 8'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_rst_out_valid", 8'(out_valid), 8'd0);
    chk("post_rst_in_ready", 8'(in_ready), 8'd1);
    in_q.delete(); exp_q.delete(); blk_n = 0; out_count = 0; first_out_iter = -1;
    for (int k = 0; k < 16; k++) in_q.push_back(vecs[0].din[k]);
    run(200, 1'b1);
    chk("post_rst_out_count", 8'(out_count), 8'd16);
    chk("post_rst_latency", 8'(first_out_iter), 8'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_rows_stream.md
# shift_rows_stream

Byte-serial forward ShiftRows stage for the AES encryption datapath, the transmit-side counterpart to the decryption path's inverse row shift. It accepts a 16-byte AES state one byte per cycle over a valid/ready stream, buffers it in two ping-pong banks, and emits the ShiftRows-permuted state one byte per cycle over a second valid/ready stream. Sustained throughput is one byte per cycle with back-pressure on both sides.

## Interface
- No parameters; block size is fixed at 16 bytes (AES-128 state).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_byte is valid this cycle.
- in_ready  output  1  block can accept a byte this cycle.
- in_byte  input  8  state byte, column-major order: byte k is row k%4, column k/4.
- out_valid  output  1  out_byte is valid this cycle.
- out_ready  input  1  downstream accepts out_byte this cycle.
- out_byte  output  8  permuted state byte, column-major order.
- out_last  output  1  high with out_valid on the 16th byte of a block.

## Operation
- Transfer occurs on a side when valid and ready are both high at a rising edge.
- Mapping: output byte k = input byte SR(k), SR(k) = 4*((k/4 + k%4) mod 4) + k%4. Examples: SR(0)=0, SR(1)=5, SR(2)=10, SR(3)=15, SR(4)=4, SR(5)=9, SR(13)=1.
- Two banks of 16 x 8-bit registers, each with a full flag.
- Write side: wr_bank (1 bit), wr_cnt (4 bits). Accepted byte stored at bank[wr_bank][wr_cnt]; wr_cnt increments and wraps 15->0; on the 16th byte, full[wr_bank] is set and wr_bank toggles.
- Read side: rd_bank (1 bit), rd_cnt (4 bits). out_byte = bank[rd_bank][SR(rd_cnt)]. On transfer rd_cnt increments and wraps 15->0; on the 16th byte, full[rd_bank] is cleared and rd_bank toggles.
- in_ready = !full[wr_bank]; out_valid = full[rd_bank]; out_last = out_valid && rd_cnt==15.
- Per-bank state cycle: EMPTY -> FILLING (first byte written) -> FULL (16th byte written) -> DRAINING (first byte read) -> EMPTY (16th byte read). full flag is high in FULL and DRAINING.
- Simultaneous completion: 16th write into one bank and 16th read from the other in the same cycle; both flags update and both pointers toggle in that cycle. No lost or duplicated block.
- Both banks full: in_ready low until the draining bank empties. Input held off, no byte dropped.
- out_byte and out_last are held stable while out_valid && !out_ready.
- Bank contents are not cleared on drain; stale data is never presented because out_valid gates it.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_byte=don't-care (banks are not reset). Internal state after reset: full=00, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0.
- Reset mid-block discards every partially written or undrained block. in_ready=1 and out_valid=0 in the first cycle after reset deasserts.
- Latency: 16th input byte accepted at edge N -> out_valid high, first permuted byte on out_byte, in the cycle after edge N.
- Throughput: with in_valid and out_ready held high, one byte per cycle in and out indefinitely, after an initial 16-cycle fill.
- out_byte is a combinational mux from registers, with no combinational path from in_* to out_*. in_ready depends only on registers.

## Structure
- Shared AES package (aes_pkg) holds: the constant STATE_BYTES=16, the byte_t type (8-bit), and the function sr_index(k) returning SR(k). The future byte-serial inverse stage reuses the package with isr_index.
- One sub-module, shift_rows_bank: a 16x8 register file with a write port and a read port addressed by 4-bit index. It is instantiated twice. Control (pointers, flags) stays in the top.

## Test plan
- Single block, FIPS-197 round 1 after SubBytes: in d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> out d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, out_last on e5 only.
- Index sweep: in bytes 00..0f -> out 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
- Back-to-back: 4 blocks with in_valid=1 and out_ready=1 continuously -> no in_ready gaps after reset, out_valid continuous from cycle 17, all bytes correct. Include the cycle where 16th write and 16th read coincide.
- Back-pressure: out_ready=0 for 40 cycles -> in_ready falls after 32 bytes accepted, out_byte stays stable. Release -> both blocks drain in order.
- Random valid/ready toggling on both sides over 100 blocks -> a scoreboard against SR(k) shows no drops, duplicates, or reordering.
- Reset asserted after 7 bytes of block 2 while block 1 is half drained -> next cycle out_valid=0, in_ready=1. A fresh block afterward is permuted correctly.
